// File: rtl/sensor_pwr_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sensor_pwr_seq_pkg
// Brief   : State codes and rail decode helpers for the sensor power sequencer.
// Revision: 1.0
// ============================================================================
package sensor_pwr_seq_pkg;

    // 4-bit codes are visible to firmware through state_o; keep them stable.
    localparam logic [3:0] ST_OFF      = 4'd0;
    localparam logic [3:0] ST_UP_IO    = 4'd1;
    localparam logic [3:0] ST_UP_CORE  = 4'd2;
    localparam logic [3:0] ST_UP_BOOST = 4'd3;
    localparam logic [3:0] ST_UP_BIAS  = 4'd4;
    localparam logic [3:0] ST_ON       = 4'd5;
    localparam logic [3:0] ST_DN_BIAS  = 4'd6;
    localparam logic [3:0] ST_DN_BOOST = 4'd7;
    localparam logic [3:0] ST_DN_CORE  = 4'd8;
    localparam logic [3:0] ST_DN_IO    = 4'd9;
    localparam logic [3:0] ST_FAULT    = 4'd10;

    typedef enum logic [3:0] {
        S_OFF      = ST_OFF,
        S_UP_IO    = ST_UP_IO,
        S_UP_CORE  = ST_UP_CORE,
        S_UP_BOOST = ST_UP_BOOST,
        S_UP_BIAS  = ST_UP_BIAS,
        S_ON       = ST_ON,
        S_DN_BIAS  = ST_DN_BIAS,
        S_DN_BOOST = ST_DN_BOOST,
        S_DN_CORE  = ST_DN_CORE,
        S_DN_IO    = ST_DN_IO,
        S_FAULT    = ST_FAULT
    } state_t;

    // Rails on per state, active high: {io, core, boost, bias}.
    function automatic logic [3:0] rails_of(input state_t s);
        logic [3:0] r;
        r = 4'b0000;
        case (s)
            S_UP_IO,    S_DN_CORE:  r = 4'b1000;
            S_UP_CORE,  S_DN_BOOST: r = 4'b1100;
            S_UP_BOOST, S_DN_BIAS:  r = 4'b1110;
            S_UP_BIAS,  S_ON:       r = 4'b1111;
            default:                r = 4'b0000;
        endcase
        return r;
    endfunction

    function automatic logic is_busy(input state_t s);
        return (s == S_UP_IO)   || (s == S_UP_CORE)  || (s == S_UP_BOOST) ||
               (s == S_UP_BIAS) || (s == S_DN_BIAS)  || (s == S_DN_BOOST) ||
               (s == S_DN_CORE) || (s == S_DN_IO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwr_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module  : pwr_dwell_timer
// Brief   : Loadable down-counter; done while the count sits at zero.
// Revision: 1.0
// ============================================================================
module pwr_dwell_timer #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/sensor_pwr_seq.sv
`default_nettype none
// ============================================================================
// Module  : sensor_pwr_seq
// Brief   : Thermal-sensor rail sequencer: ordered power-up, reverse power-down,
//           immediate all-off on fault.
// Revision: 1.0
// ============================================================================
module sensor_pwr_seq
    import sensor_pwr_seq_pkg::*;
#(
    parameter int unsigned T_IO    = 1000,
    parameter int unsigned T_CORE  = 1000,
    parameter int unsigned T_BOOST = 1000,
    parameter int unsigned T_BIAS  = 1000,
    parameter int unsigned CNT_W   = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwr_req,
    input  logic       pwr_fault,
    input  logic       bias_volt_sel_i,
    output logic       sensor_io_pwr_ena_n,
    output logic       sensor_core_pwr_ena,
    output logic       sensor_bias_boost_pwr_ena,
    output logic       sensor_bias_pwr_ena,
    output logic       sensor_bias_volt_sel,
    output logic       pwr_rdy,
    output logic       pwr_busy,
    output logic       pwr_fault_flag,
    output logic [3:0] state_o
);

    localparam logic [CNT_W-1:0] c_DW_IO    = CNT_W'(T_IO - 1);
    localparam logic [CNT_W-1:0] c_DW_CORE  = CNT_W'(T_CORE - 1);
    localparam logic [CNT_W-1:0] c_DW_BOOST = CNT_W'(T_BOOST - 1);
    localparam logic [CNT_W-1:0] c_DW_BIAS  = CNT_W'(T_BIAS - 1);

    state_t           r_state;
    state_t           w_next;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_done;
    logic [3:0]       w_rails;

    pwr_dwell_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_done  (w_done)
    );

    // Next state and dwell reload share one decode so the timer loads on the
    // same edge the state is entered.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        if (pwr_fault && (r_state != S_FAULT)) begin
            w_next = S_FAULT;
        end else begin
            case (r_state)
                S_OFF: if (pwr_req) begin
                    w_next = S_UP_IO;    w_load = 1'b1; w_load_val = c_DW_IO;
                end
                S_UP_IO: if (!pwr_req) begin
                    w_next = S_DN_IO;    w_load = 1'b1; w_load_val = c_DW_IO;
                end else if (w_done) begin
                    w_next = S_UP_CORE;  w_load = 1'b1; w_load_val = c_DW_CORE;
                end
                S_UP_CORE: if (!pwr_req) begin
                    w_next = S_DN_CORE;  w_load = 1'b1; w_load_val = c_DW_CORE;
                end else if (w_done) begin
                    w_next = S_UP_BOOST; w_load = 1'b1; w_load_val = c_DW_BOOST;
                end
                S_UP_BOOST: if (!pwr_req) begin
                    w_next = S_DN_BOOST; w_load = 1'b1; w_load_val = c_DW_BOOST;
                end else if (w_done) begin
                    w_next = S_UP_BIAS;  w_load = 1'b1; w_load_val = c_DW_BIAS;
                end
                S_UP_BIAS: if (!pwr_req) begin
                    w_next = S_DN_BIAS;  w_load = 1'b1; w_load_val = c_DW_BIAS;
                end else if (w_done) begin
                    w_next = S_ON;
                end
                S_ON: if (!pwr_req) begin
                    w_next = S_DN_BIAS;  w_load = 1'b1; w_load_val = c_DW_BIAS;
                end
                S_DN_BIAS: if (w_done) begin
                    w_next = S_DN_BOOST; w_load = 1'b1; w_load_val = c_DW_BOOST;
                end
                S_DN_BOOST: if (w_done) begin
                    w_next = S_DN_CORE;  w_load = 1'b1; w_load_val = c_DW_CORE;
                end
                S_DN_CORE: if (w_done) begin
                    w_next = S_DN_IO;    w_load = 1'b1; w_load_val = c_DW_IO;
                end
                S_DN_IO: if (w_done) begin
                    w_next = S_OFF;
                end
                S_FAULT: if (!pwr_req && !pwr_fault) begin
                    w_next = S_OFF;
                end
                default: w_next = S_FAULT;
            endcase
        end
    end

    assign w_rails = rails_of(w_next);

    // Outputs are registered from the next-state decode, so they always match
    // the registered state without any input-to-output path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state                   <= S_OFF;
            sensor_io_pwr_ena_n       <= 1'b1;
            sensor_core_pwr_ena       <= 1'b0;
            sensor_bias_boost_pwr_ena <= 1'b0;
            sensor_bias_pwr_ena       <= 1'b0;
            sensor_bias_volt_sel      <= 1'b0;
            pwr_rdy                   <= 1'b0;
            pwr_busy                  <= 1'b0;
            pwr_fault_flag            <= 1'b0;
        end else begin
            r_state                   <= w_next;
            sensor_io_pwr_ena_n       <= ~w_rails[3];
            sensor_core_pwr_ena       <= w_rails[2];
            sensor_bias_boost_pwr_ena <= w_rails[1];
            sensor_bias_pwr_ena       <= w_rails[0];
            pwr_rdy                   <= (w_next == S_ON);
            pwr_busy                  <= is_busy(w_next);
            pwr_fault_flag            <= (w_next == S_FAULT);
            if ((w_next == S_OFF) || (w_next == S_FAULT)) begin
                sensor_bias_volt_sel <= 1'b0;
            end else if ((r_state == S_OFF) && (w_next == S_UP_IO)) begin
                sensor_bias_volt_sel <= bias_volt_sel_i;
            end
        end
    end

    assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sensor_pwr_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_sensor_pwr_seq
// Brief   : Self-checking bench: vector table, directed corner sequences and
//           randomized traffic against a rail-level reference model.
// Revision: 1.0
// ============================================================================
module tb_sensor_pwr_seq;

    logic       clk = 1'b0;
    logic       rst, pwr_req, pwr_fault, bias_volt_sel_i;
    logic       io_n, core, boost, bias, vsel, rdy, busy, flag;
    logic [3:0] st;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    sensor_pwr_seq #(
        .T_IO(4), .T_CORE(5), .T_BOOST(6), .T_BIAS(7), .CNT_W(24)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .pwr_req                   (pwr_req),
        .pwr_fault                 (pwr_fault),
        .bias_volt_sel_i           (bias_volt_sel_i),
        .sensor_io_pwr_ena_n       (io_n),
        .sensor_core_pwr_ena       (core),
        .sensor_bias_boost_pwr_ena (boost),
        .sensor_bias_pwr_ena       (bias),
        .sensor_bias_volt_sel      (vsel),
        .pwr_rdy                   (rdy),
        .pwr_busy                  (busy),
        .pwr_fault_flag            (flag),
        .state_o                   (st)
    );

    // Reference model: mode + rail level + remaining dwell cycles.
    localparam int M_OFF = 0, M_UP = 1, M_ON = 2, M_DN = 3, M_FLT = 4;
    int   m_mode = M_OFF, m_lvl = 0, m_rem = 0;
    logic m_vs = 1'b0;

    function automatic int dw(input int k);
        case (k)
            1: return 4;
            2: return 5;
            3: return 6;
            default: return 7;
        endcase
    endfunction

    task automatic model_step();
        if (rst) begin
            m_mode = M_OFF; m_vs = 1'b0;
        end else if (pwr_fault && m_mode != M_FLT) begin
            m_mode = M_FLT;
        end else begin
            case (m_mode)
                M_OFF: if (pwr_req) begin
                    m_mode = M_UP; m_lvl = 1; m_rem = dw(1); m_vs = bias_volt_sel_i;
                end
                M_UP: if (!pwr_req) begin
                    m_mode = M_DN; m_rem = dw(m_lvl);
                end else if (m_rem == 1) begin
                    if (m_lvl == 4) m_mode = M_ON;
                    else begin m_lvl = m_lvl + 1; m_rem = dw(m_lvl); end
                end else m_rem = m_rem - 1;
                M_ON: if (!pwr_req) begin
                    m_mode = M_DN; m_lvl = 4; m_rem = dw(4);
                end
                M_DN: if (m_rem == 1) begin
                    if (m_lvl == 1) m_mode = M_OFF;
                    else begin m_lvl = m_lvl - 1; m_rem = dw(m_lvl); end
                end else m_rem = m_rem - 1;
                default: if (!pwr_req && !pwr_fault) m_mode = M_OFF;
            endcase
        end
    endtask

    function automatic logic [11:0] mk(input int s, input logic [3:0] rails,
                                       input logic v, input logic r,
                                       input logic b, input logic f);
        logic [3:0] s4;
        s4 = s[3:0];
        return {s4, rails, v, r, b, f};
    endfunction

    function automatic logic [11:0] model_vec();
        int n, s;
        logic [3:0] rails;
        case (m_mode)
            M_UP:    begin n = m_lvl;     s = m_lvl;      end
            M_ON:    begin n = 4;         s = 5;          end
            M_DN:    begin n = m_lvl - 1; s = 10 - m_lvl; end
            M_FLT:   begin n = 0;         s = 10;         end
            default: begin n = 0;         s = 0;          end
        endcase
        rails = {(n < 1), (n >= 2), (n >= 3), (n >= 4)};
        return mk(s, rails,
                  (m_mode == M_UP || m_mode == M_ON || m_mode == M_DN) ? m_vs : 1'b0,
                  (m_mode == M_ON), (m_mode == M_UP || m_mode == M_DN),
                  (m_mode == M_FLT));
    endfunction

    function automatic logic [11:0] dut_vec();
        return {st, io_n, core, boost, bias, vsel, rdy, busy, flag};
    endfunction

    task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h (st=%0d) expected=%h (st=%0d) t=%0t",
                     nm, got, got[11:8], exp, exp[11:8], $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            chk("model", dut_vec(), model_vec());
        end
    endtask

    typedef struct {
        logic        req;
        logic        flt;
        logic        sel;
        int          ncyc;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [20];

    initial begin
        // rails field = {io_ena_n, core, boost, bias}
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1, mk(1,  4'b0000, 1, 0, 1, 0)};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 3, mk(1,  4'b0000, 1, 0, 1, 0)};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1, mk(2,  4'b0100, 1, 0, 1, 0)};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 5, mk(3,  4'b0110, 1, 0, 1, 0)};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 6, mk(4,  4'b0111, 1, 0, 1, 0)};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 6, mk(4,  4'b0111, 1, 0, 1, 0)};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1, mk(5,  4'b0111, 1, 1, 0, 0)};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 3, mk(5,  4'b0111, 1, 1, 0, 0)};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1, mk(6,  4'b0110, 1, 0, 1, 0)};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 6, mk(6,  4'b0110, 1, 0, 1, 0)};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1, mk(7,  4'b0100, 1, 0, 1, 0)};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 6, mk(8,  4'b0000, 1, 0, 1, 0)};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 5, mk(9,  4'b1000, 1, 0, 1, 0)};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 3, mk(9,  4'b1000, 1, 0, 1, 0)};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1, mk(0,  4'b1000, 0, 0, 0, 0)};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1, mk(1,  4'b0000, 0, 0, 1, 0)};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 1, mk(10, 4'b1000, 0, 0, 0, 1)};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 4, mk(10, 4'b1000, 0, 0, 0, 1)};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 2, mk(10, 4'b1000, 0, 0, 0, 1)};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1, mk(0,  4'b1000, 0, 0, 0, 0)};

        rst = 1'b1; pwr_req = 1'b0; pwr_fault = 1'b0; bias_volt_sel_i = 1'b0;
        tick(2);
        chk("reset", dut_vec(), mk(0, 4'b1000, 0, 0, 0, 0));
        rst = 1'b0;
        tick(1);

        for (int i = 0; i < 20; i++) begin
            pwr_req = vecs[i].req; pwr_fault = vecs[i].flt; bias_volt_sel_i = vecs[i].sel;
            tick(vecs[i].ncyc);
            chk($sformatf("vec%0d", i), dut_vec(), vecs[i].exp);
        end

        // Abort during UP_BOOST with three dwell cycles left.
        pwr_req = 1'b1; bias_volt_sel_i = 1'b1;
        tick(12);
        chk("abort_pre", dut_vec(), mk(3, 4'b0110, 1, 0, 1, 0));
        pwr_req = 1'b0;
        tick(1);
        chk("abort_dn_boost", dut_vec(), mk(7, 4'b0100, 1, 0, 1, 0));
        tick(5);
        chk("abort_hold", dut_vec(), mk(7, 4'b0100, 1, 0, 1, 0));
        tick(1);
        chk("abort_core_off", dut_vec(), mk(8, 4'b0000, 1, 0, 1, 0));
        tick(9);
        chk("abort_off", dut_vec(), mk(0, 4'b1000, 0, 0, 0, 0));

        // Fault from ON with request held.
        pwr_req = 1'b1; bias_volt_sel_i = 1'b0;
        tick(23);
        chk("on_sel0", dut_vec(), mk(5, 4'b0111, 0, 1, 0, 0));
        pwr_fault = 1'b1;
        tick(1);
        chk("fault_on", dut_vec(), mk(10, 4'b1000, 0, 0, 0, 1));
        pwr_fault = 1'b0;
        tick(3);
        chk("fault_hold", dut_vec(), mk(10, 4'b1000, 0, 0, 0, 1));
        pwr_req = 1'b0;
        tick(1);
        chk("fault_clear", dut_vec(), mk(0, 4'b1000, 0, 0, 0, 0));

        // Re-request during DN_CORE, then re-sample of the bias select.
        pwr_req = 1'b1; bias_volt_sel_i = 1'b1;
        tick(23);
        pwr_req = 1'b0;
        tick(14);
        chk("rereq_dn_core", dut_vec(), mk(8, 4'b0000, 1, 0, 1, 0));
        pwr_req = 1'b1; bias_volt_sel_i = 1'b0;
        tick(5);
        chk("rereq_dn_io", dut_vec(), mk(9, 4'b1000, 1, 0, 1, 0));
        tick(4);
        chk("rereq_off", dut_vec(), mk(0, 4'b1000, 0, 0, 0, 0));
        tick(1);
        chk("rereq_up_io", dut_vec(), mk(1, 4'b0000, 0, 0, 1, 0));

        // Hard reset while in UP_BIAS.
        tick(16);
        chk("rst_pre", dut_vec(), mk(4, 4'b0111, 0, 0, 1, 0));
        rst = 1'b1;
        tick(1);
        chk("rst_kill", dut_vec(), mk(0, 4'b1000, 0, 0, 0, 0));
        rst = 1'b0; pwr_req = 1'b0;
        tick(1);

        // Randomized traffic; request toggles rarely so full sequences complete.
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(39) == 0) pwr_req = ~pwr_req;
            pwr_fault       = ($urandom_range(299) == 0);
            bias_volt_sel_i = 1'($urandom_range(1));
            rst             = ($urandom_range(1499) == 0);
            tick(1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
